// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [3:0] KEY_STAR = 4'hF;
    localparam logic [3:0] KEY_HASH = 4'hE;
    localparam logic [3:0] ROW_INIT = 4'b1110;

    // Key codes indexed [row][col]
    localparam logic [3:0] KEYMAP [NUM_ROWS][NUM_COLS] = '{
        '{4'h1,     4'h2, 4'h3,     4'hA},
        '{4'h4,     4'h5, 4'h6,     4'hB},
        '{4'h7,     4'h8, 4'h9,     4'hC},
        '{KEY_STAR, 4'h0, KEY_HASH, 4'hD}
    };

    // True when exactly one active-low column is asserted
    function automatic logic single_low(input logic [NUM_COLS-1:0] cols);
        return ($countones(~cols) == 1);
    endfunction

endpackage

// File: rtl/keypad_sync_2ff.sv
// Two-flop synchroniser for the asynchronous keypad column inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Reset to all-ones so idle (pulled-up) columns read as released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: row scan, column sync, press/release debounce, key code out.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 50_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_validn
);

    localparam int unsigned DW  = (SCAN_CYCLES > 2)     ? $clog2(SCAN_CYCLES)     : 1;
    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    state_t          r_state;
    logic [DW-1:0]   r_dwell;
    logic [DBW-1:0]  r_deb;
    logic [3:0]      r_row_n;
    logic [1:0]      r_row_idx;
    logic [1:0]      r_col_idx;
    logic [3:0]      r_col_pat;
    logic [3:0]      r_key_code;
    logic            r_key_validn;

    logic [3:0]      w_col;
    logic [1:0]      w_low_idx;
    logic            w_single;

    sync_2ff #(.WIDTH(4)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (col_n),
        .o_q   (w_col)
    );

    // Position of the low column; only meaningful when w_single is set
    always_comb begin
        w_low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!w_col[i]) w_low_idx = 2'(i);
        end
    end

    assign w_single = single_low(w_col);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SCAN;
            r_dwell      <= '0;
            r_deb        <= '0;
            r_row_n      <= ROW_INIT;
            r_row_idx    <= 2'd0;
            r_col_idx    <= 2'd0;
            r_col_pat    <= 4'hF;
            r_key_code   <= 4'hF;
            r_key_validn <= 1'b1;
        end else begin
            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_LAST) begin
                        r_dwell <= '0;
                        if (w_single) begin
                            r_col_pat <= w_col;
                            r_col_idx <= w_low_idx;
                            r_deb     <= '0;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row_n   <= {r_row_n[2:0], r_row_n[3]};
                            r_row_idx <= r_row_idx + 2'd1;
                        end
                    end else begin
                        r_dwell <= r_dwell + DW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (w_col != r_col_pat) begin
                        r_state   <= SCAN;
                        r_deb     <= '0;
                        r_dwell   <= '0;
                        r_row_n   <= {r_row_n[2:0], r_row_n[3]};
                        r_row_idx <= r_row_idx + 2'd1;
                    end else if (r_deb == DEB_LAST) begin
                        r_state      <= PRESSED;
                        r_deb        <= '0;
                        r_key_code   <= KEYMAP[r_row_idx][r_col_idx];
                        r_key_validn <= 1'b0;
                    end else begin
                        r_deb <= r_deb + DBW'(1);
                    end
                end
                PRESSED: begin
                    // Only the latched column matters; other keys are ignored
                    if (w_col[r_col_idx]) begin
                        r_state <= RELEASE;
                        r_deb   <= '0;
                    end
                end
                RELEASE: begin
                    if (!w_col[r_col_idx]) begin
                        r_state <= PRESSED;
                        r_deb   <= '0;
                    end else if (r_deb == DEB_LAST) begin
                        r_state      <= SCAN;
                        r_deb        <= '0;
                        r_dwell      <= '0;
                        r_key_validn <= 1'b1;
                        r_row_n      <= {r_row_n[2:0], r_row_n[3]};
                        r_row_idx    <= r_row_idx + 2'd1;
                    end else begin
                        r_deb <= r_deb + DBW'(1);
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    assign row_n      = r_row_n;
    assign key_code   = r_key_code;
    assign key_validn = r_key_validn;

endmodule
